// File: rtl/pwm_peripheral.sv
// PWM peripheral: 16 outputs, each off, statically on, or driven by one shared PWM waveform.
// Latency: out and pwm_sync are registered one cycle after the inputs and state that determine them.
// Backpressure: none; the counters free-run and the outputs are recomputed every cycle.
//
// Ports:
//   clk, rst                          clock; asynchronous active-high reset
//   en_reg_out_15_8 / en_reg_out_7_0  per-output enable (an enable of 0 forces the output low)
//   en_reg_pwm_15_8 / en_reg_pwm_7_0  per-output mode (1 = PWM waveform, 0 = constant high)
//   pwm_duty_cycle                    requested duty, sampled only at each period start
//   out                               registered output drive
//   pwm_sync                          one-cycle pulse on the cycle after each period start
module pwm_peripheral #(
    parameter int unsigned CLK_DIV = 3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        pwm_sync
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic [15:0] prescaler;
    logic [7:0]  pwm_cnt;
    logic [7:0]  duty_shadow;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic        tick;
    logic        period_start;
    logic [7:0]  duty_eff;
    logic        pwm_level;
    logic [15:0] out_next;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    assign tick         = (prescaler == DIV_LAST);
    assign period_start = (prescaler == 16'd0) && (pwm_cnt == 8'd0);

    // The start cycle already compares against the duty being latched on that
    // cycle, so every period (including the first after reset) runs entirely at
    // one duty value: high for exactly D*CLK_DIV cycles, and a change from 0 to
    // 255 produces no stray low cycle at the boundary.
    assign duty_eff  = period_start ? pwm_duty_cycle : duty_shadow;
    assign pwm_level = (duty_eff == 8'hFF) || (pwm_cnt < duty_eff);

    // Enable dominates mode: a disabled output is low whatever its PWM select.
    assign out_next = en_out & (~en_pwm | {16{pwm_level}});

    // Prescaler and PWM counter free-run independently of the enables so that
    // disabling outputs never disturbs the period phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= 16'd0;
            pwm_cnt   <= 8'd0;
        end else begin
            if (tick) begin
                prescaler <= 16'd0;
                pwm_cnt   <= pwm_cnt + 8'd1;
            end else begin
                prescaler <= prescaler + 16'd1;
            end
        end
    end

    // Duty is captured only at the period start so that mid-period writes
    // cannot truncate or stretch the pulse already in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_shadow <= 8'd0;
        end else if (period_start) begin
            duty_shadow <= pwm_duty_cycle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out      <= 16'h0000;
            pwm_sync <= 1'b0;
        end else begin
            out      <= out_next;
            pwm_sync <= period_start;
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: three instances (CLK_DIV = 4, 2, 1) share all inputs.
// A per-cycle scoreboard compares every output against a period-position model,
// and directed windows check hand-computed high-cycle and sync-pulse counts.
module tb_pwm_peripheral;

    logic        clk;
    logic        rst;
    logic [15:0] eo;
    logic [15:0] ep;
    logic [7:0]  duty;

    logic [2:0][15:0] dout;
    logic [2:0]       dsync;

    int checks;
    int failures;
    int fail_prints;

    pwm_peripheral #(.CLK_DIV(4)) u_div4 (
        .clk(clk), .rst(rst),
        .en_reg_out_7_0(eo[7:0]), .en_reg_out_15_8(eo[15:8]),
        .en_reg_pwm_7_0(ep[7:0]), .en_reg_pwm_15_8(ep[15:8]),
        .pwm_duty_cycle(duty), .out(dout[0]), .pwm_sync(dsync[0])
    );

    pwm_peripheral #(.CLK_DIV(2)) u_div2 (
        .clk(clk), .rst(rst),
        .en_reg_out_7_0(eo[7:0]), .en_reg_out_15_8(eo[15:8]),
        .en_reg_pwm_7_0(ep[7:0]), .en_reg_pwm_15_8(ep[15:8]),
        .pwm_duty_cycle(duty), .out(dout[1]), .pwm_sync(dsync[1])
    );

    pwm_peripheral #(.CLK_DIV(1)) u_div1 (
        .clk(clk), .rst(rst),
        .en_reg_out_7_0(eo[7:0]), .en_reg_out_15_8(eo[15:8]),
        .en_reg_pwm_7_0(ep[7:0]), .en_reg_pwm_15_8(ep[15:8]),
        .pwm_duty_cycle(duty), .out(dout[2]), .pwm_sync(dsync[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int div_of(input int i);
        if (i == 0) return 4;
        if (i == 1) return 2;
        return 1;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (fail_prints < 40) begin
                fail_prints++;
                $display("FAIL %s dut%0d actual=%0h expected=%0h at %0t", name, idx, act, exp, $time);
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [2:0][15:0] o;
        logic [2:0]       s;
    } exp_t;

    exp_t exp_q[$];
    int   mcyc[3];
    int   msh[3];

    // Model: position within the period is the cycle count since reset modulo
    // 256*div; the duty in force is whatever was presented at position 0.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < 3; i++) begin
                mcyc[i] <= 0;
                msh[i]  <= 0;
            end
        end else begin
            exp_t e;
            e = '0;
            for (int i = 0; i < 3; i++) begin
                int ph;
                int sh;
                logic lvl;
                ph  = mcyc[i] % (256 * div_of(i));
                sh  = (ph == 0) ? int'(duty) : msh[i];
                lvl = (sh == 255) || (ph < sh * div_of(i));
                e.o[i] = eo & (~ep | {16{lvl}});
                e.s[i] = (ph == 0);
                msh[i]  <= sh;
                mcyc[i] <= mcyc[i] + 1;
            end
            exp_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst || exp_q.size() == 0) e = '0;
        else e = exp_q.pop_front();
        for (int i = 0; i < 3; i++)
            chk("scoreboard", i, {15'd0, dsync[i], dout[i]}, {15'd0, e.s[i], e.o[i]});
    end

    // ---------------- directed measurement windows ----------------
    int hi[3];
    int sy[3];
    int nz0;
    int nf0;

    task automatic clr();
        for (int i = 0; i < 3; i++) begin
            hi[i] = 0;
            sy[i] = 0;
        end
        nz0 = 0;
        nf0 = 0;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                hi[i] += int'(dout[i][0]);
                sy[i] += int'(dsync[i]);
            end
            if (dout[0] != 16'h0000) nz0++;
            if (dout[0] != 16'hFFFF) nf0++;
        end
    endtask

    // Reset, load inputs, release; returns #1 after the first (period-start) edge.
    task automatic rst_seq(input logic [7:0] d, input logic [15:0] o, input logic [15:0] p);
        @(posedge clk);
        #1;
        rst  = 1'b1;
        duty = d;
        eo   = o;
        ep   = p;
        #1;
        for (int i = 0; i < 3; i++) chk("reset_out", i, int'(dout[i]), 0);
        chk("reset_sync", 0, int'(dsync), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("first_sync", 0, int'(dsync), 3'b111);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        fail_prints = 0;
        rst  = 1'b1;
        eo   = 16'h0000;
        ep   = 16'h0000;
        duty = 8'd0;

        // 50% duty on bit 0: 512 high per 1024 samples at every divider.
        rst_seq(8'd128, 16'h0001, 16'h0001);
        clr();
        run(1024);
        for (int i = 0; i < 3; i++) chk("duty128_high", i, hi[i], 512);
        chk("duty128_sync", 0, sy[0], 1);
        chk("duty128_sync", 1, sy[1], 2);
        chk("duty128_sync", 2, sy[2], 4);
        clr();
        run(1024);
        chk("duty128_high_p2", 0, hi[0], 512);
        chk("duty128_sync_p2", 0, sy[0], 1);

        // Static enables appear one cycle after the write, in any phase.
        eo = 16'hA5A5;
        ep = 16'h0000;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk("static_a5a5", i, int'(dout[i]), 16'hA5A5);
        eo = 16'h0000;
        ep = 16'hFFFF;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk("enable_dominates", i, int'(dout[i]), 0);
        run(37);

        // Duty 0 for one full div4 period, then 255 with no low cycle.
        rst_seq(8'd0, 16'hFFFF, 16'hFFFF);
        clr();
        run(500);
        duty = 8'd255;
        run(524);
        chk("duty0_nonzero_cycles", 0, nz0, 0);
        clr();
        run(1024);
        chk("duty255_notall_cycles", 0, nf0, 0);

        // div2: duty 64 then 192 written at counter 100; next period uses 192.
        rst_seq(8'd64, 16'h0001, 16'h0001);
        clr();
        run(200);
        duty = 8'd192;
        run(312);
        chk("shadow_cur_period", 1, hi[1], 128);
        clr();
        run(512);
        chk("shadow_next_period", 1, hi[1], 384);

        // Reset mid-period at div4 counter 200, duty 50.
        rst_seq(8'd50, 16'h0003, 16'h0001);
        clr();
        run(800);
        #2;
        chk("static_bit_before_rst", 0, int'(dout[0][1]), 1);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) chk("async_reset_out", i, int'(dout[i]), 0);
        rst_seq(8'd50, 16'h0003, 16'h0001);
        clr();
        run(1024);
        for (int i = 0; i < 3; i++) chk("after_reset_high", i, hi[i], 200);
        chk("after_reset_sync", 0, sy[0], 1);

        // div1, duty 1: exactly one high cycle per 256.
        rst_seq(8'd1, 16'h0001, 16'h0001);
        clr();
        run(512);
        chk("duty1_high", 2, hi[2], 2);
        chk("duty1_sync", 2, sy[2], 2);
        chk("duty1_high", 0, hi[0], 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
